// File: rtl/axi_lite_slave_ctrl_if.sv
// axi_lite_slave_ctrl_if -- AXI4-Lite signal bundle for axi_lite_slave_ctrl.
//
// Signals (directions as seen by the slave):
//   AW: awaddr[31:0], awvalid in; awready out
//   W : wdata[31:0], wstrb[3:0], wvalid in; wready out
//   B : bresp[1:0], bvalid out; bready in
//   AR: araddr[31:0], arvalid in; arready out
//   R : rdata[31:0], rresp[1:0], rvalid out; rready in
//
// Modports: master (drives valids/payloads, B/R readies), slave (the reverse).
interface axi_lite_slave_ctrl_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_slave_ctrl.sv
// axi_lite_slave_ctrl -- AXI4-Lite slave in front of a single-port register
// file of NUM_REGS 32-bit words.
//
// Ports:
//   aclk        clock, all state changes on the rising edge
//   aresetn     asynchronous active-low reset
//   bus         axi_lite_slave_ctrl_if.slave (AW/W/B/AR/R channels)
//   wr_state_o  write-channel FSM state (0 IDLE, 1 HOLD_PART, 2 COMMIT_WAIT, 3 RESP)
//   rd_state_o  read-channel FSM state  (0 IDLE, 1 ACC_WAIT, 2 RESP)
//
// Optional feature macro: AXI_LITE_SLAVE_ERR_RESP_EN -- when defined,
// out-of-range accesses answer SLVERR (2'b10); otherwise they answer OKAY.
// Out-of-range writes are always dropped and out-of-range reads return 0.
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid and ready are both 1; valid never waits for ready, and the
// slave holds its own valid and payload steady until the transfer happens.
//
// AW and W are captured into one-entry holders. A write commits once both
// are held; a read accesses the array once AR is held. The array takes one
// access per cycle; on contention the loser gets priority next time.
module axi_lite_slave_ctrl #(
  parameter int NUM_REGS = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  axi_lite_slave_ctrl_if.slave        bus,
  output logic [1:0]                  wr_state_o,
  output logic [1:0]                  rd_state_o
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_LITE_SLAVE_ERR_RESP_EN
  localparam logic [1:0] RESP_OOR = 2'b10;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif

  typedef enum logic [1:0] {
    W_IDLE        = 2'd0,
    W_HOLD_PART   = 2'd1,
    W_COMMIT_WAIT = 2'd2,
    W_RESP        = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE     = 2'd0,
    R_ACC_WAIT = 2'd1,
    R_RESP     = 2'd2
  } rd_state_e;

  wr_state_e          wr_state_q;
  rd_state_e          rd_state_q;
  logic               aw_full_q, w_full_q;
  logic [IDX_W-1:0]   aw_idx_q, ar_idx_q;
  logic               aw_oor_q, ar_oor_q;
  logic [31:0]        w_data_q;
  logic [3:0]         w_strb_q;
  logic               awready_q, wready_q, arready_q;
  logic               bvalid_q, rvalid_q;
  logic [1:0]         bresp_q, rresp_q;
  logic [31:0]        rdata_q;
  logic               prio_wr_q;
  logic [31:0]        regs_q [NUM_REGS];

  logic aw_hs, w_hs, ar_hs;
  logic aw_full_n, w_full_n;
  logic wr_req, rd_req, wr_gnt, rd_gnt;

  // The byte-offset bits never select anything.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.awaddr[1:0], bus.araddr[1:0]};

  assign aw_hs = bus.awvalid & awready_q;
  assign w_hs  = bus.wvalid  & wready_q;
  assign ar_hs = bus.arvalid & arready_q;

  // Holder occupancy as it will be after this edge.
  assign aw_full_n = aw_full_q | aw_hs;
  assign w_full_n  = w_full_q  | w_hs;

  assign wr_req = (wr_state_q == W_COMMIT_WAIT);
  assign rd_req = (rd_state_q == R_ACC_WAIT);
  assign wr_gnt = wr_req & (~rd_req | prio_wr_q);
  assign rd_gnt = rd_req & (~wr_req | ~prio_wr_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      aw_idx_q   <= '0;
      ar_idx_q   <= '0;
      aw_oor_q   <= 1'b0;
      ar_oor_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      prio_wr_q  <= 1'b1;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      // Priority only moves when both sides actually compete.
      if (wr_req && rd_req) prio_wr_q <= rd_gnt;

      // Write channel. Readies are rebuilt from the next holder state, so
      // they also rise on the first edge after reset is released.
      case (wr_state_q)
        W_IDLE, W_HOLD_PART: begin
          if (aw_hs) begin
            aw_idx_q <= bus.awaddr[IDX_W+1:2];
            aw_oor_q <= |bus.awaddr[31:IDX_W+2];
          end
          if (w_hs) begin
            w_data_q <= bus.wdata;
            w_strb_q <= bus.wstrb;
          end
          aw_full_q <= aw_full_n;
          w_full_q  <= w_full_n;
          awready_q <= ~aw_full_n;
          wready_q  <= ~w_full_n;
          if (aw_full_n && w_full_n)      wr_state_q <= W_COMMIT_WAIT;
          else if (aw_full_n || w_full_n) wr_state_q <= W_HOLD_PART;
          else                            wr_state_q <= W_IDLE;
        end
        W_COMMIT_WAIT: begin
          if (wr_gnt) begin
            if (!aw_oor_q) begin
              for (int b = 0; b < 4; b++) begin
                if (w_strb_q[b]) regs_q[aw_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
              end
            end
            bvalid_q   <= 1'b1;
            bresp_q    <= aw_oor_q ? RESP_OOR : RESP_OKAY;
            wr_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          // Holders stay occupied until B is accepted, which keeps
          // awready/wready low for the whole response phase.
          if (bus.bready) begin
            bvalid_q   <= 1'b0;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase

      // Read channel.
      case (rd_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            ar_idx_q   <= bus.araddr[IDX_W+1:2];
            ar_oor_q   <= |bus.araddr[31:IDX_W+2];
            arready_q  <= 1'b0;
            rd_state_q <= R_ACC_WAIT;
          end else begin
            arready_q  <= 1'b1;
          end
        end
        R_ACC_WAIT: begin
          if (rd_gnt) begin
            rdata_q    <= ar_oor_q ? 32'h0 : regs_q[ar_idx_q];
            rresp_q    <= ar_oor_q ? RESP_OOR : RESP_OKAY;
            rvalid_q   <= 1'b1;
            rd_state_q <= R_RESP;
          end
        end
        R_RESP: begin
          if (bus.rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;

  assign wr_state_o = wr_state_q;
  assign rd_state_o = rd_state_q;

endmodule

// File: tb/tb_axi_lite_slave_ctrl.sv
// tb_axi_lite_slave_ctrl -- directed, table-driven bench for
// axi_lite_slave_ctrl (NUM_REGS = 16). Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_axi_lite_slave_ctrl;

`ifdef AXI_LITE_SLAVE_ERR_RESP_EN
  localparam logic [1:0] EXP_OOR = 2'b10;
`else
  localparam logic [1:0] EXP_OOR = 2'b00;
`endif
  localparam int TMO = 100;

  // ---------------- clock / reset ----------------
  logic aclk;
  logic aresetn;
  logic [1:0] wr_state;
  logic [1:0] rd_state;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  axi_lite_slave_ctrl_if bus ();

  axi_lite_slave_ctrl #(.NUM_REGS(16)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .bus        (bus),
    .wr_state_o (wr_state),
    .rd_state_o (rd_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: no response within %0d cycles", name, TMO);
  endtask

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic send_aw(input logic [31:0] addr);
    int n;
    n = 0;
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    while (!bus.awready && n < TMO) begin @(negedge aclk); n++; end
    if (n >= TMO) timeout("aw_handshake");
    @(negedge aclk);
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    int n;
    n = 0;
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.wvalid = 1'b1;
    while (!bus.wready && n < TMO) begin @(negedge aclk); n++; end
    if (n >= TMO) timeout("w_handshake");
    @(negedge aclk);
    bus.wvalid = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int n;
    n = 0;
    bus.bready = 1'b1;
    while (!bus.bvalid && n < TMO) begin @(negedge aclk); n++; end
    if (n >= TMO) timeout("b_response");
    resp = bus.bresp;
    @(negedge aclk);
    bus.bready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           output logic [1:0] resp);
    fork
      begin repeat (aw_dly) @(negedge aclk); send_aw(addr); end
      begin repeat (w_dly) @(negedge aclk); send_w(data, strb); end
    join
    wait_b(resp);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    n = 0;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    while (!bus.arready && n < TMO) begin @(negedge aclk); n++; end
    if (n >= TMO) timeout("ar_handshake");
    @(negedge aclk);
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    n = 0;
    while (!bus.rvalid && n < TMO) begin @(negedge aclk); n++; end
    if (n >= TMO) timeout("r_response");
    data = bus.rdata;
    resp = bus.rresp;
    @(negedge aclk);
    bus.rready = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb   = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly;
    int          w_dly;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [1:0]  br;

    // Register contents accumulate from one row to the next.
    vecs[0] = '{32'h08,  32'hDEADBEEF, 4'hF,    0, 0, 32'hDEADBEEF, 2'b00};
    vecs[1] = '{32'h10,  32'hFFFFFFFF, 4'hF,    2, 0, 32'hFFFFFFFF, 2'b00};
    vecs[2] = '{32'h10,  32'h00000000, 4'b0101, 0, 3, 32'hFF00FF00, 2'b00};
    vecs[3] = '{32'h10,  32'h12345678, 4'b1000, 1, 1, 32'h1200FF00, 2'b00};
    vecs[4] = '{32'h13,  32'hA5A5A5A5, 4'b0000, 0, 0, 32'h1200FF00, 2'b00};
    vecs[5] = '{32'h3C,  32'hCAFEF00D, 4'hF,    4, 1, 32'hCAFEF00D, 2'b00};
    vecs[6] = '{32'h00,  32'h00000001, 4'b0001, 0, 0, 32'h00000001, 2'b00};
    vecs[7] = '{32'h100, 32'h55555555, 4'hF,    0, 2, 32'h00000000, EXP_OOR};

    // ---- reset values ----
    clear_inputs();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    check("rst_awready", {31'b0, bus.awready}, 32'h0);
    check("rst_wready",  {31'b0, bus.wready},  32'h0);
    check("rst_arready", {31'b0, bus.arready}, 32'h0);
    check("rst_bvalid",  {31'b0, bus.bvalid},  32'h0);
    check("rst_rvalid",  {31'b0, bus.rvalid},  32'h0);
    check("rst_bresp",   {30'b0, bus.bresp},   32'h0);
    check("rst_rresp",   {30'b0, bus.rresp},   32'h0);
    check("rst_rdata",   bus.rdata,            32'h0);
    check("rst_wr_state", {30'b0, wr_state},   32'h0);
    check("rst_rd_state", {30'b0, rd_state},   32'h0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rel_awready", {31'b0, bus.awready}, 32'h1);
    check("rel_arready", {31'b0, bus.arready}, 32'h1);

    // ---- AW+W same cycle, write latency ----
    bus.awaddr = 32'h08; bus.awvalid = 1'b1;
    bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("wlat_bvalid_n1", {31'b0, bus.bvalid}, 32'h0);
    check("wlat_state_n1",  {30'b0, wr_state},   32'h2);
    check("wlat_awready_n1", {31'b0, bus.awready}, 32'h0);
    @(negedge aclk);
    check("wlat_bvalid_n2", {31'b0, bus.bvalid}, 32'h1);
    check("wlat_bresp_n2",  {30'b0, bus.bresp},  32'h0);
    @(negedge aclk);
    bus.bready = 1'b0;
    check("wlat_bvalid_done", {31'b0, bus.bvalid},  32'h0);
    check("wlat_awready_done", {31'b0, bus.awready}, 32'h1);

    // ---- read latency and R backpressure ----
    bus.araddr = 32'h08; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(negedge aclk);
    bus.arvalid = 1'b0;
    check("rlat_rvalid_n1",  {31'b0, bus.rvalid},  32'h0);
    check("rlat_arready_n1", {31'b0, bus.arready}, 32'h0);
    @(negedge aclk);
    check("rlat_rvalid_n2", {31'b0, bus.rvalid}, 32'h1);
    check("rlat_rdata_n2",  bus.rdata,           32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check($sformatf("bp_rvalid_%0d", i),  {31'b0, bus.rvalid},  32'h1);
      check($sformatf("bp_rdata_%0d", i),   bus.rdata,            32'hDEADBEEF);
      check($sformatf("bp_arready_%0d", i), {31'b0, bus.arready}, 32'h0);
    end
    bus.rready = 1'b1;
    @(negedge aclk);
    bus.rready = 1'b0;
    check("bp_rvalid_after",  {31'b0, bus.rvalid},  32'h0);
    check("bp_arready_after", {31'b0, bus.arready}, 32'h1);

    // ---- table-driven write/readback ----
    for (int i = 0; i < 8; i++) begin
      axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].aw_dly, vecs[i].w_dly, br);
      check($sformatf("vec%0d_bresp", i), {30'b0, br}, {30'b0, vecs[i].exp_resp});
      exp_q.push_back(vecs[i].exp_rdata);
      axi_read(vecs[i].addr, rd, rr);
      check($sformatf("vec%0d_rdata", i), rd, exp_q.pop_front());
      check($sformatf("vec%0d_rresp", i), {30'b0, rr}, {30'b0, vecs[i].exp_resp});
    end
    // 0x100 aliases word 0 in the low bits; word 0 must be untouched.
    axi_read(32'h00, rd, rr);
    check("oor_reg0_unchanged", rd, 32'h00000001);

    // ---- W three cycles ahead of AW, partial strobe ----
    axi_write(32'h04, 32'hFFFFFFFF, 4'hF, 0, 0, br);
    send_w(32'h1234ABCD, 4'b0011);
    check("wfirst_state",   {30'b0, wr_state},    32'h1);
    check("wfirst_wready",  {31'b0, bus.wready},  32'h0);
    check("wfirst_awready", {31'b0, bus.awready}, 32'h1);
    repeat (2) @(negedge aclk);
    send_aw(32'h04);
    wait_b(br);
    check("wfirst_bresp", {30'b0, br}, 32'h0);
    axi_read(32'h04, rd, rr);
    check("wfirst_rdata", rd, 32'hFFFFABCD);

    // ---- reset while B is pending ----
    fork
      send_aw(32'h08);
      send_w(32'h00000077, 4'hF);
    join
    begin
      int n;
      n = 0;
      while (!bus.bvalid && n < TMO) begin @(negedge aclk); n++; end
      if (n >= TMO) timeout("rst_mid_bvalid");
    end
    aresetn = 1'b0;
    #1;
    check("rstmid_bvalid",  {31'b0, bus.bvalid},  32'h0);
    check("rstmid_awready", {31'b0, bus.awready}, 32'h0);
    check("rstmid_arready", {31'b0, bus.arready}, 32'h0);
    clear_inputs();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rstmid_rel_awready", {31'b0, bus.awready}, 32'h1);
    check("rstmid_rel_wready",  {31'b0, bus.wready},  32'h1);
    check("rstmid_rel_arready", {31'b0, bus.arready}, 32'h1);
    check("rstmid_rel_bvalid",  {31'b0, bus.bvalid},  32'h0);
    for (int i = 0; i < 16; i++) begin
      axi_read(32'(i * 4), rd, rr);
      check($sformatf("rstmid_reg%0d", i), rd, 32'h0);
    end

    // ---- read/write contention, write first after reset ----
    bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
    bus.wdata = 32'h11112222; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 32'h0C; bus.arvalid = 1'b1;
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge aclk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    @(negedge aclk);
    check("arb1_bvalid", {31'b0, bus.bvalid}, 32'h1);
    check("arb1_rvalid", {31'b0, bus.rvalid}, 32'h0);
    @(negedge aclk);
    check("arb1_rvalid_late", {31'b0, bus.rvalid}, 32'h1);
    check("arb1_rdata",       bus.rdata,           32'h11112222);
    @(negedge aclk);
    check("arb1_arready", {31'b0, bus.arready}, 32'h1);
    check("arb1_awready", {31'b0, bus.awready}, 32'h1);

    // ---- second contention: read now wins ----
    bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
    bus.wdata = 32'h33334444; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 32'h0C; bus.arvalid = 1'b1;
    @(negedge aclk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    @(negedge aclk);
    check("arb2_rvalid", {31'b0, bus.rvalid}, 32'h1);
    check("arb2_rdata",  bus.rdata,           32'h11112222);
    check("arb2_bvalid", {31'b0, bus.bvalid}, 32'h0);
    @(negedge aclk);
    check("arb2_bvalid_late", {31'b0, bus.bvalid}, 32'h1);
    @(negedge aclk);
    bus.bready = 1'b0; bus.rready = 1'b0;
    axi_read(32'h0C, rd, rr);
    check("arb2_readback", rd, 32'h33334444);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_ctrl.md
AXI_LITE_SLAVE_CTRL -- requirements
Module: axi_lite_slave_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 32-bit registers in the internal single-port register file (power of 2, 2..256).
REQ-002 SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-003 SHALL have port aclk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port aresetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have write-address ports: awaddr in 32, awvalid in 1, awready out 1.
REQ-006 SHALL have write-data ports: wdata in 32, wstrb in 4 (byte enables), wvalid in 1, wready out 1.
REQ-007 SHALL have write-response ports: bresp out 2, bvalid out 1, bready in 1.
REQ-008 SHALL have read-address ports: araddr in 32, arvalid in 1, arready out 1.
REQ-009 SHALL have read-data ports: rdata out 32, rresp out 2, rvalid out 1, rready in 1.

Function
REQ-010 SHALL decode the word index from addr[log2(NUM_REGS)+1:2], ignore addr[1:0], and treat an address as in range iff all higher bits are 0.
REQ-011 SHALL capture AW and W independently into one-entry holding registers; awready = AW holder empty and no B pending; wready = W holder empty and no B pending.
REQ-012 SHALL accept AW and W in the same cycle or in either order, with any gap between them.
REQ-013 SHALL assert arready only when the AR holder is empty and no R is pending.
REQ-014 SHALL arbitrate the register file between write commit (both AW and W held) and read access (AR held), one access per cycle.
REQ-015 SHALL resolve simultaneous requests round-robin: the loser gets next priority; after reset, write has priority.
REQ-016 SHALL update only the bytes whose wstrb bit is 1 on write commit; wstrb=0 commits nothing but still responds.
REQ-017 SHALL have write latency: handshake completes in cycle N, commit in N+1 if granted, bvalid=1 from N+2.
REQ-018 SHALL have read latency: AR handshake in cycle N, access in N+1 if granted, rvalid=1 with registered rdata from N+2.
REQ-019 SHALL hold bvalid/bresp until bready=1, and rvalid/rdata/rresp until rready=1; holders are freed in the handshake cycle, so awready, wready and arready may rise in the next cycle.
REQ-020 SHALL respond with OKAY (2'b00) for in-range accesses.
REQ-021 SHALL keep outputs stable under backpressure: while valid and not ready, rdata and bresp do not change.
REQ-022 SHALL implement per-channel state machines: write channel IDLE -> HOLD_PART (one of AW/W held) -> COMMIT_WAIT -> RESP -> IDLE; read channel IDLE -> ACC_WAIT -> RESP -> IDLE.
REQ-023 SHALL order a read and a write to the same register as granted: a granted write is visible to any read granted in a later cycle.

Reset
REQ-024 SHALL, on aresetn=0, asynchronously clear awready, wready, arready, bvalid and rvalid to 0, bresp and rresp to 2'b00, and rdata to 0.
REQ-025 SHALL, on aresetn=0, clear all registers to 0, empty all holders, return FSMs to IDLE and set priority to write.
REQ-026 SHALL, on reset mid-transaction, discard the transaction with no response; ready signals rise in the first cycle after aresetn deasserts.

Configuration
REQ-027 SHALL, with macro AXI_LITE_SLAVE_ERR_RESP_EN defined, respond SLVERR (2'b10) to out-of-range accesses: writes are dropped and rdata=0.
REQ-028 SHALL, without AXI_LITE_SLAVE_ERR_RESP_EN, respond OKAY to out-of-range accesses: writes are silently dropped and rdata=0.

Verification
REQ-029 SHALL cover: AW 0x08 and W 0xDEADBEEF, wstrb 4'hF, same cycle, bready=1 -> bvalid 2 cycles later with bresp 00; a read of 0x08 then returns 0xDEADBEEF.
REQ-030 SHALL cover: W arrives 3 cycles before AW 0x04, wstrb 4'b0011, data 0x1234ABCD over 0xFFFFFFFF -> register becomes 0xFFFFABCD.
REQ-031 SHALL cover: AR 0x0C and a write commit to 0x0C contend for the register file right after reset -> write granted first, read returns the new data; a second contention -> read wins.
REQ-032 SHALL cover: rready held 0 for 5 cycles -> rvalid/rdata stable, arready=0 throughout, arready=1 the cycle after the handshake.
REQ-033 SHALL cover: write to 0x100 with NUM_REGS=16 -> bresp 10 with the macro, 00 without, and no register changes in either case.
REQ-034 SHALL cover: aresetn low while bvalid=1 -> bvalid=0 immediately, all registers read back 0 after reset.
